// File: rtl/neuron_seq_pkg.sv
// Shared types and constants for the neuron sequencer: FSM state encoding and
// coefficient slot layout (four slots per logical neuron).
package neuron_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WAIT,
    DONE
  } state_t;

  localparam int SLOT_W1          = 0;
  localparam int SLOT_W2          = 1;
  localparam int SLOT_B1          = 2;
  localparam int SLOT_B2          = 3;
  localparam int SLOTS_PER_NEURON = 4;

  // Index width never collapses to zero bits for a single-neuron layer.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_seq_if.sv
// Sequencer bundle: run control, coefficient port, neuron operand bus and result stream.
// master = sequencer side, slave = layer control / neuron / consumer side.
interface neuron_seq_if
  import neuron_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_NEURONS = 4
);

  localparam int AW = $clog2(SLOTS_PER_NEURON * NUM_NEURONS);
  localparam int IW = idx_width(NUM_NEURONS);

  logic             start;
  logic [WIDTH-1:0] x_1;
  logic [WIDTH-1:0] x_2;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_wdata;
  logic             cfg_err;
  logic [WIDTH-1:0] a_1;
  logic [WIDTH-1:0] a_2;
  logic [WIDTH-1:0] w_1;
  logic [WIDTH-1:0] w_2;
  logic [WIDTH-1:0] b_1;
  logic [WIDTH-1:0] b_2;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    out_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start, x_1, x_2, cfg_we, cfg_addr, cfg_wdata, y, out_ready,
    output cfg_err, a_1, a_2, w_1, w_2, b_1, b_2, out_valid, out_data, out_idx, busy, done
  );

  modport slave (
    output start, x_1, x_2, cfg_we, cfg_addr, cfg_wdata, y, out_ready,
    input  cfg_err, a_1, a_2, w_1, w_2, b_1, b_2, out_valid, out_data, out_idx, busy, done
  );

endinterface

// File: rtl/neuron_seq_coef.sv
// Per-neuron coefficient register file; write takes effect next edge, read is combinational.
// Bias slots exist only with NEURON_SEQ_BIAS_EN; otherwise bias reads are 0 and bias writes vanish.
module neuron_seq_coef
  import neuron_seq_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int NUM_NEURONS = 4,
  localparam int AW          = $clog2(SLOTS_PER_NEURON * NUM_NEURONS),
  localparam int IW          = idx_width(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] w_1,
  output logic [WIDTH-1:0] w_2,
  output logic [WIDTH-1:0] b_1,
  output logic [WIDTH-1:0] b_2
);

  logic [WIDTH-1:0] w1_tab [NUM_NEURONS];
  logic [WIDTH-1:0] w2_tab [NUM_NEURONS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        w1_tab[n] <= '0;
        w2_tab[n] <= '0;
      end
    end else if (we) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (addr == AW'(n * SLOTS_PER_NEURON + SLOT_W1)) w1_tab[n] <= wdata;
        if (addr == AW'(n * SLOTS_PER_NEURON + SLOT_W2)) w2_tab[n] <= wdata;
      end
    end
  end

  assign w_1 = w1_tab[idx];
  assign w_2 = w2_tab[idx];

`ifdef NEURON_SEQ_BIAS_EN
  logic [WIDTH-1:0] b1_tab [NUM_NEURONS];
  logic [WIDTH-1:0] b2_tab [NUM_NEURONS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        b1_tab[n] <= '0;
        b2_tab[n] <= '0;
      end
    end else if (we) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (addr == AW'(n * SLOTS_PER_NEURON + SLOT_B1)) b1_tab[n] <= wdata;
        if (addr == AW'(n * SLOTS_PER_NEURON + SLOT_B2)) b2_tab[n] <= wdata;
      end
    end
  end

  assign b_1 = b1_tab[idx];
  assign b_2 = b2_tab[idx];
`else
  assign b_1 = '0;
  assign b_2 = '0;
`endif

endmodule

// File: rtl/neuron_seq.sv
// Time-multiplexes one combinational neuron over NUM_NEURONS coefficient sets (bias via NEURON_SEQ_BIAS_EN).
// 3 cycles per neuron with out_ready high; result is held while !out_ready, each stalled cycle adds one.
module neuron_seq
  import neuron_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_NEURONS = 4
) (
  input logic          clk,
  input logic          rst,
  neuron_seq_if.master bus
);

  localparam int            IW        = idx_width(NUM_NEURONS);
  localparam int            NUM_SLOTS = SLOTS_PER_NEURON * NUM_NEURONS;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_NEURONS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] x1_q;
  logic [WIDTH-1:0] x2_q;
  logic [WIDTH-1:0] coef_w1;
  logic [WIDTH-1:0] coef_w2;
  logic [WIDTH-1:0] coef_b1;
  logic [WIDTH-1:0] coef_b2;
  logic             idle;
  logic             hs;
  logic             cfg_bad;
  logic             cfg_ok;

  assign idle    = (state == IDLE);
  assign hs      = bus.out_valid && bus.out_ready;
  assign cfg_bad = (int'(bus.cfg_addr) >= NUM_SLOTS);
  // A write coinciding with an accepted start lands before ISSUE reads the table.
  assign cfg_ok  = bus.cfg_we && idle && !cfg_bad;

  neuron_seq_coef #(
    .WIDTH       (WIDTH),
    .NUM_NEURONS (NUM_NEURONS)
  ) u_coef (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_ok),
    .addr  (bus.cfg_addr),
    .wdata (bus.cfg_wdata),
    .idx   (idx),
    .w_1   (coef_w1),
    .w_2   (coef_w2),
    .b_1   (coef_b1),
    .b_2   (coef_b2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = WAIT;
      WAIT: begin
        if (hs) state_nxt = (idx == LAST_IDX) ? DONE : ISSUE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      x1_q          <= '0;
      x2_q          <= '0;
      bus.a_1       <= '0;
      bus.a_2       <= '0;
      bus.w_1       <= '0;
      bus.w_2       <= '0;
      bus.b_1       <= '0;
      bus.b_2       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.cfg_err   <= 1'b0;
    end else begin
      bus.cfg_err <= bus.cfg_we && (!idle || cfg_bad);
      case (state)
        IDLE: begin
          if (bus.start) begin
            x1_q <= bus.x_1;
            x2_q <= bus.x_2;
            idx  <= '0;
          end
        end
        ISSUE: begin
          bus.a_1 <= x1_q;
          bus.a_2 <= x2_q;
          bus.w_1 <= coef_w1;
          bus.w_2 <= coef_w2;
          bus.b_1 <= coef_b1;
          bus.b_2 <= coef_b2;
        end
        CAPTURE: begin
          bus.out_data  <= bus.y;
          bus.out_idx   <= idx;
          bus.out_valid <= 1'b1;
        end
        WAIT: begin
          if (hs) begin
            bus.out_valid <= 1'b0;
            if (idx != LAST_IDX) idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// Randomised and directed bench for neuron_seq against an edge-level behavioural model.
module tb_neuron_seq;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int NSLOT = 4 * N;
`ifdef NEURON_SEQ_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_seq_if #(.WIDTH(WIDTH), .NUM_NEURONS(N)) bus ();
  neuron_seq #(.WIDTH(WIDTH), .NUM_NEURONS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Non-power-of-two layer, so an out-of-range address is representable.
  neuron_seq_if #(.WIDTH(WIDTH), .NUM_NEURONS(3)) bus3 ();
  neuron_seq #(.WIDTH(WIDTH), .NUM_NEURONS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Stand-in neuron: weighted sum plus both biases, wrapping at 32 bits.
  function automatic logic [31:0] nf(input logic [31:0] a1, a2, w1, w2, b1, b2);
    return a1 * w1 + a2 * w2 + b1 + b2;
  endfunction

  assign bus.y  = nf(bus.a_1, bus.a_2, bus.w_1, bus.w_2, bus.b_1, bus.b_2);
  assign bus3.y = nf(bus3.a_1, bus3.a_2, bus3.w_1, bus3.w_2, bus3.b_1, bus3.b_2);

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the run is a list of N results; each one becomes visible two
  // edges after the run starts or after the previous result is taken.
  logic [31:0] tab [NSLOT];
  logic [31:0] m_op [6];
  logic [31:0] m_x1, m_x2, m_data;
  bit          m_busy, m_valid, m_done, m_err;
  int          m_cnt, m_k, m_idx;
  int          hs_q[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NSLOT; i++) tab[i] = '0;
        for (int i = 0; i < 6; i++) m_op[i] = '0;
        m_x1 = '0; m_x2 = '0; m_data = '0;
        m_busy = 0; m_valid = 0; m_done = 0; m_err = 0;
        m_cnt = 0; m_k = 0; m_idx = 0;
      end else begin
        cyc++;
        if (bus.out_valid && bus.out_ready) hs_q.push_back(cyc);
        m_err = bus.cfg_we && (m_busy || int'(bus.cfg_addr) >= NSLOT);
        if (bus.cfg_we && !m_busy && int'(bus.cfg_addr) < NSLOT &&
            (BIAS_EN || bus.cfg_addr[1:0] < 2'd2))
          tab[bus.cfg_addr] = bus.cfg_wdata;
        if (!m_busy) begin
          if (bus.start) begin
            m_busy = 1; m_cnt = 2; m_k = 0;
            m_x1 = bus.x_1; m_x2 = bus.x_2;
          end
        end else if (m_done) begin
          m_done = 0; m_busy = 0;
        end else if (m_valid) begin
          if (bus.out_ready) begin
            m_valid = 0;
            m_k++;
            if (m_k == N) m_done = 1;
            else          m_cnt = 2;
          end
        end else begin
          m_cnt--;
          if (m_cnt == 1) begin
            m_op[0] = m_x1;
            m_op[1] = m_x2;
            for (int s = 0; s < 4; s++) m_op[2+s] = tab[m_k*4+s];
          end else begin
            m_valid = 1;
            m_data  = nf(m_op[0], m_op[1], m_op[2], m_op[3], m_op[4], m_op[5]);
            m_idx   = m_k;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
        chk("out_data", bus.out_data, m_data);
        chk("out_idx", 32'(bus.out_idx), m_idx);
        chk("a_1", bus.a_1, m_op[0]);
        chk("a_2", bus.a_2, m_op[1]);
        chk("w_1", bus.w_1, m_op[2]);
        chk("w_2", bus.w_2, m_op[3]);
        chk("b_1", bus.b_1, m_op[4]);
        chk("b_2", bus.b_2, m_op[5]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int addr, input logic [31:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'(addr);
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic kick(input logic [31:0] a, input logic [31:0] b, output int e0);
    bus.x_1   = a;
    bus.x_2   = b;
    bus.start = 1'b1;
    hs_q.delete();
    tick();
    bus.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(bus.done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int n;
    bus.start = 0; bus.x_1 = 0; bus.x_2 = 0; bus.cfg_we = 0; bus.cfg_addr = 0;
    bus.cfg_wdata = 0; bus.out_ready = 0;
    bus3.start = 0; bus3.x_1 = 0; bus3.x_2 = 0; bus3.cfg_we = 0; bus3.cfg_addr = 0;
    bus3.cfg_wdata = 0; bus3.out_ready = 1;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    cmp_en = 1'b1;

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_a_1", bus.a_1, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);

    // Neuron 0 from the worked example; neurons 1..3 distinct small values.
    cfg(0, 32'd2); cfg(1, 32'd3); cfg(2, 32'd1); cfg(3, 32'd4);
    for (int k = 1; k < N; k++) begin
      cfg(k*4,   32'(k + 1));
      cfg(k*4+1, 32'(-k));
      cfg(k*4+2, 32'(k));
      cfg(k*4+3, 32'(2 * k));
    end

    // Operand load, first capture and full-run timing.
    bus.out_ready = 1'b1;
    kick(32'd5, 32'd7, e0);
    tick();
    chk("t1_a_1", bus.a_1, 32'd5);
    chk("t1_a_2", bus.a_2, 32'd7);
    chk("t1_w_1", bus.w_1, 32'd2);
    chk("t1_w_2", bus.w_2, 32'd3);
    chk("t1_b_1", bus.b_1, BIAS_EN ? 32'd1 : 32'd0);
    chk("t1_b_2", bus.b_2, BIAS_EN ? 32'd4 : 32'd0);
    tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data", bus.out_data, BIAS_EN ? 32'd36 : 32'd31);
    chk("t1_idx", 32'(bus.out_idx), 32'd0);
    wait_done(40);
    chk("t1_done_edge", cyc, e0 + 12);
    chk("t1_hs_count", hs_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) chk("t1_hs_edge", hs_q[i], e0 + 3 * (i + 1));
    tick();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
    chk("t1_busy_fall", 32'(bus.busy), 32'd0);

    // Five stalled cycles on neuron 1.
    kick(32'd5, 32'd7, e0);
    repeat (5) tick();
    chk("t2_idx1", 32'(bus.out_idx), 32'd1);
    bus.out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_hold_idx", 32'(bus.out_idx), 32'd1);
      chk("t2_hold_data", bus.out_data, BIAS_EN ? 32'd6 : 32'd3);
    end
    bus.out_ready = 1'b1;
    wait_done(40);
    chk("t2_done_edge", cyc, e0 + 17);
    tick();

    // Write while busy is rejected and leaves the table alone.
    kick(32'd5, 32'd7, e0);
    tick();
    cfg(0, 32'd99);
    chk("t3_busy_err", 32'(bus.cfg_err), 32'd1);
    tick();
    chk("t3_err_pulse", 32'(bus.cfg_err), 32'd0);
    wait_done(40);
    tick();
    kick(32'd5, 32'd7, e0);
    repeat (2) tick();
    chk("t3_table_kept", bus.out_data, BIAS_EN ? 32'd36 : 32'd31);
    wait_done(40);
    tick();

    // Bias slot write: stored only in the bias build, never an error.
    cfg(2, 32'd9);
    chk("t4_bias_no_err", 32'(bus.cfg_err), 32'd0);
    kick(32'd5, 32'd7, e0);
    tick();
    chk("t4_b_1", bus.b_1, BIAS_EN ? 32'd9 : 32'd0);
    wait_done(40);
    tick();

    // Out-of-range address on the 3-neuron instance.
    bus3.cfg_we = 1'b1; bus3.cfg_addr = 4'd12; bus3.cfg_wdata = 32'd1;
    tick();
    bus3.cfg_we = 1'b0;
    chk("oob_err", 32'(bus3.cfg_err), 32'd1);
    tick();
    chk("oob_pulse", 32'(bus3.cfg_err), 32'd0);
    bus3.cfg_we = 1'b1; bus3.cfg_addr = 4'd11;
    tick();
    bus3.cfg_we = 1'b0;
    chk("inrange_no_err", 32'(bus3.cfg_err), 32'd0);

    // Reset while neuron 2 waits.
    kick(32'd5, 32'd7, e0);
    repeat (8) tick();
    chk("t5_idx2", 32'(bus.out_idx), 32'd2);
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_a_1", bus.a_1, 32'd0);
    chk("t5_rst_w_1", bus.w_1, 32'd0);
    chk("t5_rst_data", bus.out_data, 32'd0);
    chk("t5_rst_idx", 32'(bus.out_idx), 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("t5_no_done", 32'(bus.done), 32'd0);
      chk("t5_no_valid", 32'(bus.out_valid), 32'd0);
    end
    kick(32'd5, 32'd7, e0);
    tick();
    chk("t5_zero_w_1", bus.w_1, 32'd0);
    chk("t5_a_1", bus.a_1, 32'd5);
    tick();
    chk("t5_zero_data", bus.out_data, 32'd0);
    wait_done(40);
    tick();

    // Random traffic: starts, writes (legal and rejected), backpressure, rare resets.
    for (int c = 0; c < 3000; c++) begin
      bus.start     = ($urandom_range(0, 5) == 0);
      bus.x_1       = $urandom;
      bus.x_2       = $urandom;
      bus.cfg_we    = ($urandom_range(0, 3) == 0);
      bus.cfg_addr  = 4'($urandom_range(0, 15));
      bus.cfg_wdata = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 699) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    bus.start = 1'b0; bus.cfg_we = 1'b0; bus.out_ready = 1'b1;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(bus.busy), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
